// File: rtl/bit_count_pkg.sv
// Shared types and constants for the bit-count scheduler and its arbiter.
// Optional watchdog build macro: BIT_COUNT_SCHED_WATCHDOG_EN.
package bit_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  // Extra S_RUN cycles tolerated beyond DATA_W before the watchdog fires.
  localparam int WDOG_LIMIT = 4;

  function automatic int clog2_res(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_count_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr,
// wrapping modulo N_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_index,
  output logic                     o_valid
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_j;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path through the block leaves a value unassigned (no latch inferred).
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_j = ID_W'(w_sum - (ID_W+1)'(N_REQ));
      else                           w_j = w_sum[ID_W-1:0];
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_index      = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_count_scheduler.sv
// Shares one bit-counter among N_REQ requesters: round-robin grant, start/done
// handshake, tagged result. Optional watchdog: BIT_COUNT_SCHED_WATCHDOG_EN.
module bit_count_scheduler
  import bit_count_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int RES_W  = clog2_res(DATA_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      resp_valid,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [RES_W-1:0]          resp_count,
  output logic                      cnt_s,
  output logic [DATA_W-1:0]         cnt_a,
  input  logic                      cnt_done,
  input  logic [RES_W-1:0]          cnt_result
`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
  ,
  output logic                      err
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [N_REQ-1:0]  r_grant;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [RES_W-1:0]  r_resp_count;
  logic [DATA_W-1:0] r_cnt_a;

  logic [N_REQ-1:0]  w_arb_grant;
  logic [ID_W-1:0]   w_arb_idx;
  logic              w_arb_valid;
  logic [ID_W-1:0]   w_ptr_next;
  logic              w_start;
  logic [DATA_W-1:0] w_ops [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_index (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) w_ops[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign w_ptr_next = (w_arb_idx == ID_W'(N_REQ-1)) ? '0 : w_arb_idx + 1'b1;
  // A done level left over from an earlier job blocks arbitration until it clears.
  assign w_start    = w_arb_valid && !cnt_done;

`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
  localparam int RUN_CNT_W = $clog2(DATA_W + WDOG_LIMIT + 1);
  logic [RUN_CNT_W-1:0] r_run_cnt;
  logic                 r_err;
  logic                 w_timeout;

  assign w_timeout = (r_run_cnt == RUN_CNT_W'(DATA_W + WDOG_LIMIT));
  assign err       = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_run_cnt <= '0;
    else if (r_state == S_RUN)  r_run_cnt <= r_run_cnt + 1'b1;
    else                        r_run_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cur_id     <= '0;
      r_grant      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_count <= '0;
      r_cnt_a      <= '0;
`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
      r_err        <= 1'b0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values and the block order cannot create races.
      r_grant      <= '0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt_a  <= w_ops[w_arb_idx];
            r_cur_id <= w_arb_idx;
            r_grant  <= w_arb_grant;
            r_ptr    <= w_ptr_next;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          if (cnt_done) begin
            r_resp_count <= cnt_result;
            r_resp_id    <= r_cur_id;
            r_resp_valid <= 1'b1;
            r_state      <= S_REL;
          end
`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
          else if (w_timeout) begin
            r_resp_count <= '0;
            r_resp_id    <= r_cur_id;
            r_resp_valid <= 1'b1;
            r_err        <= 1'b1;
            r_state      <= S_REL;
          end
`endif
        end
        S_REL:   if (!cnt_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Start is decoded from state so reset drops it asynchronously.
  assign cnt_s      = (r_state == S_RUN);
  assign cnt_a      = r_cnt_a;
  assign grant      = r_grant;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_count = r_resp_count;

endmodule

// File: tb/tb_bit_count_scheduler.sv
// Directed and randomized checks of bit_count_scheduler against a
// round-robin/popcount reference model and a behavioural bit-counter.
module tb_bit_count_scheduler;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    grant;
  logic            resp_valid;
  logic [0:0]      resp_id;
  logic [RW-1:0]   resp_count;
  logic            cnt_s;
  logic [DW-1:0]   cnt_a;
  logic            cnt_done;
  logic [RW-1:0]   cnt_result;
`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
  logic            err;
`endif

  // Behavioural counter: loads while s is low, strips one set bit per cycle.
  logic [DW-1:0] m_a = '0;
  logic [RW-1:0] m_cnt = '0;
  logic          m_done = 1'b0;
  int            ovr = 0;  // 0: model drives done, 1: force low, 2: force high

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_model = 0;

  bit_count_scheduler #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .cnt_s      (cnt_s),
    .cnt_a      (cnt_a),
    .cnt_done   (cnt_done),
    .cnt_result (cnt_result)
`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cnt_s) begin
      m_a    <= cnt_a;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (!m_done) begin
      if (m_a == '0) m_done <= 1'b1;
      else begin
        m_a   <= m_a & (m_a - 1'b1);
        m_cnt <= m_cnt + 1'b1;
      end
    end
  end

  assign cnt_done   = (ovr == 0) ? m_done : (ovr == 2);
  assign cnt_result = m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Runs one job for requester w; returns on the cycle after resp_valid.
  task automatic serve_one(input int w, input string tag);
    logic [DW-1:0] op;
    op = DW'(req_data >> (w * DW));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check({tag, "_grant"}, 32'(grant), 32'(1) << w);
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'(op));
    check({tag, "_load_s"}, 32'(cnt_s), 32'(0));
    for (int i = 0; i < DW + 14; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(1));
    check({tag, "_resp_id"}, 32'(resp_id), 32'(w));
    check({tag, "_resp_count"}, 32'(resp_count), 32'($countones(op)));
    ptr_model = (w + 1) % N;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_model = 0;
  endtask

  initial begin
    int cnt_g, cnt_hi, cnt_rv;
    logic [N-1:0] mask;

    // Reset state
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_resp_id", 32'(resp_id), 32'(0));
    check("rst_resp_count", 32'(resp_count), 32'(0));
    check("rst_cnt_s", 32'(cnt_s), 32'(0));
    check("rst_cnt_a", 32'(cnt_a), 32'(0));
    reset = 1'b0;

    // Single request
    req_data = {8'h00, 8'hB5};
    req = 2'b01;
    serve_one(0, "single");
    req = 2'b00;

    // Simultaneous requests after reset
    pulse_reset();
    req_data = {8'hFF, 8'h0F};
    req = 2'b11;
    serve_one(0, "simul0");
    req = 2'b10;
    serve_one(1, "simul1");
    req = 2'b00;

    // Fairness with both requests held
    req_data = {8'h3C, 8'hA1};
    req = 2'b11;
    for (int j = 0; j < 4; j++) serve_one(j % 2, "fair");
    req = 2'b00;

    // Zero operand, then confirm the FSM is back to idle
    req_data = {8'hFF, 8'h00};
    req = 2'b01;
    serve_one(0, "zero");
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("zero_idle_s", 32'(cnt_s), 32'(0));

    // Stale done in idle: no start until it clears
    ovr = 2;
    req_data = {8'h00, 8'h81};
    req = 2'b01;
    cnt_g = 0; cnt_hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (grant != '0) cnt_g++;
      if (cnt_s) cnt_hi++;
    end
    check("stale_grants", 32'(cnt_g), 32'(0));
    check("stale_cnt_s", 32'(cnt_hi), 32'(0));
    ovr = 0;
    serve_one(0, "stale_after");
    req = 2'b00;

    // Reset mid-run; pointer was left at 1
    req_data = {8'h0F, 8'hFF};
    req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check("mid_grant", 32'(grant), 32'(1));
    @(negedge clk);
    @(negedge clk);
    check("mid_running", 32'(cnt_s), 32'(1));
    #2 reset = 1'b1;
    req = 2'b00;
    #1;
    check("mid_rst_cnt_s", 32'(cnt_s), 32'(0));
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    ptr_model = 0;
    cnt_rv = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid) cnt_rv++;
    end
    check("mid_no_resp", 32'(cnt_rv), 32'(0));
    req = 2'b11;
    serve_one(0, "mid_next0");
    req = 2'b10;
    serve_one(1, "mid_next1");
    req = 2'b00;

    // Randomized rounds against the round-robin/popcount model
    for (int r = 0; r < 12; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      req_data = (N*DW)'($urandom);
      req = mask;
      while (mask != '0) begin
        int w;
        w = rr_pick(mask, ptr_model);
        serve_one(w, "rand");
        mask[w] = 1'b0;
        req = mask;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef BIT_COUNT_SCHED_WATCHDOG_EN
    // Watchdog: done never rises
    pulse_reset();
    ovr = 1;
    req_data = {8'h00, 8'h03};
    req = 2'b01;
    for (int i = 0; i < DW + 20; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check("wd_resp_valid", 32'(resp_valid), 32'(1));
    check("wd_resp_count", 32'(resp_count), 32'(0));
    check("wd_err", 32'(err), 32'(1));
    @(negedge clk);
    req = 2'b00;
    ovr = 0;
    repeat (5) @(negedge clk);
    check("wd_err_sticky", 32'(err), 32'(1));
    pulse_reset();
    check("wd_err_cleared", 32'(err), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
